// File: rtl/game_over_sequencer.sv
// Game-over banner sequencer: freezes play, drops the banner to centre,
// blinks it, then waits for a fresh restart press and pulses restart.
module game_over_sequencer #(
  parameter int BANNER_W     = 73,
  parameter int SCREEN_W     = 576,
  parameter int X_SCREEN     = (SCREEN_W - BANNER_W) / 2,
  parameter int Y_START      = 0,
  parameter int Y_TARGET     = 115,
  parameter int DROP_STEP    = 4,
  parameter int BLINK_FRAMES = 15,
  parameter int HOLD_FRAMES  = 120
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        collision_info,
  input  logic        new_frame_in,
  input  logic        restart_btn_in,
  input  logic [11:0] offset_background_in,
  output logic [12:0] x_out,
  output logic [9:0]  y_out,
  output logic        frame_index_out,
  output logic        banner_visible_out,
  output logic        freeze_out,
  output logic        restart_out
);

  localparam int FCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DROP,
    HOLD,
    ARMED,
    RESTART
  } state_t;

  state_t         state_q, state_d;
  logic [12:0]    x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic           fi_q, fi_d;
  logic           vis_q, vis_d;
  logic           frz_q, frz_d;
  logic           rp_q, rp_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           btn_prev_q;

  logic           btn_rise;
  logic [10:0]    y_sum;
  logic [9:0]     y_step;
  logic           blink_hit;
  logic           fi_blink;
  logic [BCW-1:0] bcnt_blink;

  assign btn_rise   = restart_btn_in & ~btn_prev_q;
  // Sum is one bit wider so a step past the target cannot wrap.
  assign y_sum      = {1'b0, y_q} + 11'(DROP_STEP);
  assign y_step     = (y_sum >= 11'(Y_TARGET)) ?
                      10'(Y_TARGET) : y_sum[9:0];
  assign blink_hit  = (bcnt_q == BCW'(BLINK_FRAMES - 1));
  assign fi_blink   = blink_hit ? ~fi_q : fi_q;
  assign bcnt_blink = blink_hit ? '0 : bcnt_q + 1'b1;

  // Next-state and next-output logic; everything lands in registers.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fi_d    = fi_q;
    vis_d   = vis_q;
    frz_d   = frz_q;
    rp_d    = 1'b0;
    fcnt_d  = fcnt_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        y_d    = 10'(Y_START);
        fi_d   = 1'b0;
        vis_d  = 1'b0;
        frz_d  = 1'b0;
        fcnt_d = '0;
        bcnt_d = '0;
        if (collision_info) begin
          state_d = DROP;
          x_d     = {1'b0, offset_background_in}
                    + 13'(X_SCREEN);
          vis_d   = 1'b1;
          frz_d   = 1'b1;
        end
      end
      DROP: begin
        vis_d = 1'b1;
        frz_d = 1'b1;
        fi_d  = 1'b0;
        if (new_frame_in) begin
          y_d = y_step;
          if (y_step == 10'(Y_TARGET)) begin
            state_d = HOLD;
            fcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
      end
      HOLD: begin
        if (new_frame_in) begin
          fcnt_d = fcnt_q + 1'b1;
          fi_d   = fi_blink;
          bcnt_d = bcnt_blink;
          if (fcnt_q == FCW'(HOLD_FRAMES - 1))
            state_d = ARMED;
        end
      end
      ARMED: begin
        if (btn_rise) begin
          state_d = RESTART;
          rp_d    = 1'b1;
          vis_d   = 1'b0;
          frz_d   = 1'b1;
        end else if (new_frame_in) begin
          fi_d   = fi_blink;
          bcnt_d = bcnt_blink;
        end
      end
      RESTART: begin
        state_d = IDLE;
        y_d     = 10'(Y_START);
        fi_d    = 1'b0;
        vis_d   = 1'b0;
        frz_d   = 1'b0;
        fcnt_d  = '0;
        bcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; the button history resets high so a
  // button held through reset cannot look like a fresh press.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= 10'(Y_START);
      fi_q       <= 1'b0;
      vis_q      <= 1'b0;
      frz_q      <= 1'b0;
      rp_q       <= 1'b0;
      fcnt_q     <= '0;
      bcnt_q     <= '0;
      btn_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fi_q       <= fi_d;
      vis_q      <= vis_d;
      frz_q      <= frz_d;
      rp_q       <= rp_d;
      fcnt_q     <= fcnt_d;
      bcnt_q     <= bcnt_d;
      btn_prev_q <= restart_btn_in;
    end
  end

  assign x_out              = x_q;
  assign y_out              = y_q;
  assign frame_index_out    = fi_q;
  assign banner_visible_out = vis_q;
  assign freeze_out         = frz_q;
  assign restart_out        = rp_q;

endmodule

// File: tb/tb_game_over_sequencer.sv
// Bench for game_over_sequencer: table vectors plus hand sequences,
// expectations queued at drive time and checked after the edge.
module tb_game_over_sequencer;

  typedef struct packed {
    logic [12:0] x;
    logic [9:0]  y;
    logic        fi;
    logic        vis;
    logic        frz;
    logic        rp;
  } out_t;

  typedef struct {
    logic        c;
    logic        nf;
    logic        b;
    logic        rn;
    logic [11:0] off;
    out_t        e;
    string       nm;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        coll;
  logic        nf;
  logic        btn;
  logic [11:0] off;
  logic [12:0] x_out;
  logic [9:0]  y_out;
  logic        fi_out;
  logic        vis_out;
  logic        frz_out;
  logic        rp_out;

  int total = 0;
  int bad   = 0;

  out_t  exp_q[$];
  out_t  msk_q[$];
  string nm_q[$];

  game_over_sequencer dut (
    .pixel_clk_in         (clk),
    .rst_in               (rst_n),
    .collision_info       (coll),
    .new_frame_in         (nf),
    .restart_btn_in       (btn),
    .offset_background_in (off),
    .x_out                (x_out),
    .y_out                (y_out),
    .frame_index_out      (fi_out),
    .banner_visible_out   (vis_out),
    .freeze_out           (frz_out),
    .restart_out          (rp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input int x, input int y,
                              input bit f, input bit v,
                              input bit z, input bit r);
    out_t o;
    o.x   = 13'(x);
    o.y   = 10'(y);
    o.fi  = f;
    o.vis = v;
    o.frz = z;
    o.rp  = r;
    return o;
  endfunction

  function automatic vec_t mkv(input bit c, input bit n,
                               input bit b, input bit r,
                               input int o, input out_t e,
                               input string nm);
    vec_t v;
    v.c   = c;
    v.nf  = n;
    v.b   = b;
    v.rn  = r;
    v.off = 12'(o);
    v.e   = e;
    v.nm  = nm;
    return v;
  endfunction

  task automatic check();
    out_t a, e, m;
    string n;
    a = {x_out, y_out, fi_out, vis_out, frz_out, rp_out};
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    n = nm_q.pop_front();
    total++;
    if ((a & m) !== (e & m)) begin
      bad++;
      $display("FAIL %s got x=%0d y=%0d fi=%0b vis=%0b frz=%0b rp=%0b want x=%0d y=%0d fi=%0b vis=%0b frz=%0b rp=%0b",
               n, a.x, a.y, a.fi, a.vis, a.frz, a.rp,
               e.x, e.y, e.fi, e.vis, e.frz, e.rp);
    end
  endtask

  task automatic cyc(input bit c, input bit n, input bit b,
                     input bit r, input int o, input out_t e,
                     input out_t m, input string nm);
    @(negedge clk);
    coll  = c;
    nf    = n;
    btn   = b;
    rst_n = r;
    off   = 12'(o);
    exp_q.push_back(e);
    msk_q.push_back(m);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    check();
  endtask

  vec_t tbl[7];
  out_t all1;
  out_t ctl;

  initial begin
    int yy;
    bit f;
    all1  = '1;
    ctl   = mk(0, 0, 0, 1, 1, 1);
    rst_n = 1'b0;
    coll  = 1'b0;
    nf    = 1'b0;
    btn   = 1'b0;
    off   = '0;

    tbl[0] = mkv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0), "reset");
    tbl[1] = mkv(1, 1, 1, 0, 9, mk(0, 0, 0, 0, 0, 0), "reset_busy");
    tbl[2] = mkv(0, 1, 0, 1, 0, mk(0, 0, 0, 0, 0, 0), "idle_nf");
    tbl[3] = mkv(0, 0, 1, 1, 0, mk(0, 0, 0, 0, 0, 0), "idle_btn");
    tbl[4] = mkv(1, 0, 0, 1, 1000,
                 mk(1251, 0, 0, 1, 1, 0), "collide");
    tbl[5] = mkv(1, 0, 0, 1, 7,
                 mk(1251, 0, 0, 1, 1, 0), "coll_held");
    tbl[6] = mkv(0, 0, 0, 1, 7,
                 mk(1251, 0, 0, 1, 1, 0), "drop_quiet");

    foreach (tbl[i])
      cyc(tbl[i].c, tbl[i].nf, tbl[i].b, tbl[i].rn,
          int'(tbl[i].off), tbl[i].e, all1, tbl[i].nm);

    // Drop: 29 pulses with a quiet cycle after each.
    for (int k = 1; k <= 29; k++) begin
      yy = (4 * k > 115) ? 115 : 4 * k;
      cyc(k == 10, 1, 0, 1, 5,
          mk(1251, yy, 0, 1, 1, 0), all1, "drop_step");
      cyc(0, 0, 0, 1, 0,
          mk(1251, yy, 0, 1, 1, 0), all1, "drop_gap");
    end

    // Hold: 120 pulses, blinking every 15, presses ignored,
    // button held down from pulse 100 into ARMED.
    for (int p = 1; p <= 120; p++) begin
      f = ((p / 15) % 2) == 1;
      cyc(p == 50, 1, (p < 100) ? (p % 4 == 1) : 1'b1, 1, 9,
          mk(1251, 115, f, 1, 1, 0), all1, "hold");
    end

    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 1, 0,
          mk(1251, 115, 0, 1, 1, 0), all1, "armed_held");
    cyc(0, 0, 0, 1, 0,
        mk(1251, 115, 0, 1, 1, 0), all1, "armed_release");
    for (int q = 1; q <= 15; q++)
      cyc(0, 1, 0, 1, 0,
          mk(1251, 115, q == 15, 1, 1, 0), all1, "armed_blink");

    cyc(0, 0, 1, 1, 0, mk(0, 0, 0, 0, 1, 1), ctl, "restart");
    cyc(0, 0, 1, 1, 0,
        mk(1251, 0, 0, 0, 0, 0), all1, "post_restart");
    cyc(0, 0, 1, 1, 0,
        mk(1251, 0, 0, 0, 0, 0), all1, "idle_again");

    // Collision with a simultaneous frame pulse does not step y.
    cyc(1, 1, 0, 1, 2000,
        mk(2251, 0, 0, 1, 1, 0), all1, "coll_nf");
    for (int k = 1; k <= 15; k++)
      cyc(0, 1, 0, 1, 0,
          mk(2251, 4 * k, 0, 1, 1, 0), all1, "drop2");

    cyc(1, 1, 1, 0, 3, mk(0, 0, 0, 0, 0, 0), all1, "mid_reset");
    cyc(0, 1, 0, 1, 3, mk(0, 0, 0, 0, 0, 0), all1, "reset_idle");
    cyc(1, 0, 0, 1, 0,
        mk(251, 0, 0, 1, 1, 0), all1, "recollide");
    cyc(0, 1, 0, 1, 0,
        mk(251, 4, 0, 1, 1, 0), all1, "redrop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_over_sequencer.md
# game_over_sequencer

- Controls the game-over banner sprite addresser.
- On a player collision it:
  - freezes gameplay;
  - drops the banner from the top of the play area to screen centre;
  - blinks between the two banner animation frames;
  - after a minimum hold time, waits for the player's restart button and issues a one-cycle restart pulse.
- Sits between collision detection / user input and the banner addresser. Drives the banner's world x, y, frame index and visibility.

## Interface

Parameters:
- BANNER_W, 73: banner width in pixels; used for horizontal centring.
- SCREEN_W, 576: visible play-area width.
- X_SCREEN, (SCREEN_W-BANNER_W)/2 = 251: banner screen-space x.
- Y_START, 0: banner y at drop start.
- Y_TARGET, 115: banner resting y.
- DROP_STEP, 4: pixels moved down per frame during the drop.
- BLINK_FRAMES, 15: frames between frame-index toggles.
- HOLD_FRAMES, 120: frames spent at Y_TARGET before restart is accepted.

Ports:
- pixel_clk_in, in, 1: pixel clock; the only clock.
- rst_in, in, 1: reset, synchronous, active-low.
- collision_info, in, 1: player collision, level or pulse.
- new_frame_in, in, 1: one-cycle pulse once per video frame, at the start of vertical blank.
- restart_btn_in, in, 1: debounced restart button, active-high.
- offset_background_in, in, 12: current background scroll offset.
- x_out, out, 13: banner world x = latched offset + X_SCREEN.
- y_out, out, 10: banner y.
- frame_index_out, out, 1: animation frame selector.
- banner_visible_out, out, 1: gates the banner's in-sprite into the pixel mux.
- freeze_out, out, 1: halts game logic and scrolling.
- restart_out, out, 1: one-cycle pulse requesting game reset.

## Operation

- All outputs are registered.
- States: IDLE, DROP, HOLD, ARMED, RESTART.
- IDLE:
  - Outputs: visible=0, freeze=0, restart=0, y=Y_START, frame_index=0, frame_cnt=0.
  - If collision_info=1 on any edge: latch x_out = {1'b0, offset_background_in} + X_SCREEN, then go to DROP.
  - A new_frame_in in that same cycle does not step y.
- DROP:
  - Outputs: visible=1, freeze=1.
  - On each new_frame_in, compute the sum in 11 bits: y ← min(y+DROP_STEP, Y_TARGET).
  - When the written value equals Y_TARGET: go to HOLD with frame_cnt=0 and blink_cnt=0.
  - frame_index stays 0 during DROP.
- HOLD:
  - On each new_frame_in: frame_cnt++ and blink_cnt++.
  - When blink_cnt reaches BLINK_FRAMES-1: toggle frame_index and clear blink_cnt.
  - When frame_cnt reaches HOLD_FRAMES-1 on a new_frame_in: go to ARMED.
- ARMED:
  - Blinking continues with the same rule.
  - A rising edge of restart_btn_in goes to RESTART. A rising edge is current=1 with the registered previous sample=0.
  - A button held down since HOLD does not trigger; it must be released and pressed again.
- RESTART:
  - Lasts exactly one cycle.
  - Outputs: restart_out=1, visible=0, freeze=1.
  - Next state is IDLE with all IDLE values.
- Rules that apply in every state:
  - collision_info outside IDLE is ignored.
  - The button edge register samples in every state.
  - x_out holds its latched value until the next collision in IDLE.
- Reset:
  - rst_in=0 on any edge, including mid-DROP, mid-HOLD or in RESTART, forces IDLE values.
  - Reset values: x_out=0, y_out=Y_START, frame_index=0, visible=0, freeze=0, restart=0.
  - The button-previous register resets to 1, so a button held through reset does not fire.

## Timing

- Collision sampled at edge N → visible and freeze are 1 from edge N (visible in cycle N+1); x_out is valid at the same edge.
- y_out and frame_index change only at the edge that samples new_frame_in. Their values are stable across the whole active video, so the banner never tears.
- Drop latency with defaults: 29 new_frame_in pulses. The y sequence is 0,4,…,112,115.
- Minimum HOLD time: HOLD_FRAMES new_frame_in pulses after reaching Y_TARGET.
- Button rising edge sampled at edge M in ARMED → restart_out=1 for cycle M+1 only → IDLE from edge M+1.
- Gameplay is released at the next edge: freeze=0 in cycle M+2.
- Counter widths: frame_cnt ≥ clog2(HOLD_FRAMES); blink_cnt ≥ clog2(BLINK_FRAMES). Neither counter may wrap before its compare.

## Test plan

- Reset then a one-cycle collision with offset_background_in=1000 → next cycle: x_out=1251, y_out=0, visible=1, freeze=1, frame_index=0.
- Apply 29 new_frame_in pulses → y_out=4,8,…,112,115. The 29th pulse enters HOLD; further pulses never move y past 115.
- In HOLD, frame_index toggles at the 15th, 30th, … new_frame_in pulses. restart_btn_in presses before the 120th pulse give restart_out=0.
- Button held from HOLD into ARMED → no restart. Release, then press → exactly one restart_out pulse one cycle later, then IDLE, freeze=0, y=0.
- Collision and new_frame_in in the same IDLE cycle → DROP with y=0. Collision re-asserted during DROP/HOLD → x_out unchanged, no state change.
- rst_in=0 for one cycle mid-DROP (y=60) → next cycle all reset values, state IDLE. A subsequent collision restarts the drop from y=0.
